vga_glyph_line: RTL and testbench
=================================

# vga_glyph_line

Glyph line renderer between the 640x480 VGA timing stage and the video DAC. During each horizontal blanking interval it fetches one pixel row of a glyph strip from an external synchronous font ROM into a line register. During the active interval it turns the current pixel coordinate into a registered 24-bit RGB value. This replaces the fixed hard-coded bitmap with ROM-backed content at a constant two-cycle latency.

## Interface
Parameters:
- N_GLYPH, 19: glyphs per strip (strip width = N_GLYPH*GLYPH_W px).
- GLYPH_W, 16: glyph width in px; power of two.
- GLYPH_H, 32: glyph height in rows.
- X0, 144: strip left edge, active-pixel coordinates.
- Y0, 160: strip top edge, active-line coordinates.
- ADDR_W, 10: ROM address width; must satisfy 2^ADDR_W >= N_GLYPH*GLYPH_H.
- FG, 24'hFF0000: colour for a set bit ({R,G,B}).
- BG, 24'h000000: colour for a clear bit, in-strip and outside it.

Ports:
- CLK_25  in  1  pixel clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- LINE_START  in  1  one-cycle pulse at the start of horizontal blanking.
- LINE_Y  in  11  active line number (0..479) to be shown after this blanking; sampled with LINE_START.
- PIX_X  in  11  active pixel x (0..639).
- PIX_Y  in  11  active line y (0..479).
- PIX_DE  in  1  high while PIX_X/PIX_Y is a visible pixel.
- ROM_EN  out  1  read strobe.
- ROM_ADDR  out  ADDR_W  read address = row*N_GLYPH + glyph index.
- ROM_DATA  in  GLYPH_W  row word; valid exactly one cycle after ROM_EN; MSB = leftmost pixel.
- FETCH_BUSY  out  1  high while a fetch is in progress.
- VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
- OUT_DE  out  1  PIX_DE delayed to align with RGB.

## Operation
Fetch FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE: on LINE_START, row = LINE_Y - Y0.
  - If LINE_Y is in [Y0, Y0+GLYPH_H): go to ISSUE with index i = 0.
  - Otherwise: clear all N_GLYPH line words to 0 in that cycle, issue no ROM read, stay in IDLE.
- ISSUE: each cycle drive ROM_EN=1 and ROM_ADDR=row*N_GLYPH+i, then i++. After i = N_GLYPH-1 is issued, go to DRAIN.
- DRAIN: capture the last ROM_DATA into word[N_GLYPH-1], then go to IDLE.
- Capture rule: ROM_DATA is written to word[i_prev] on every cycle following a ROM_EN=1 cycle.
- LINE_START while ISSUE or DRAIN: abort the fetch and restart per the IDLE rule with the new LINE_Y. The in-flight read is discarded, not written.
- FETCH_BUSY = 1 in ISSUE and DRAIN.
- Render pipeline:
  - Stage 1 registers: in-window flag (PIX_DE and PIX_X in [X0, X0+N_GLYPH*GLYPH_W) and PIX_Y in [Y0, Y0+GLYPH_H)), word index (PIX_X-X0)/GLYPH_W, bit index GLYPH_W-1-((PIX_X-X0) mod GLYPH_W), and PIX_DE.
  - Stage 2 registers: RGB = FG if in-window and word[idx][bit], else BG; also OUT_DE.
  - With OUT_DE=0, RGB = 0 regardless of BG.
- Subtractions use 11-bit unsigned math, evaluated only inside the window; out-of-window indices are don't-care but must not index past word[N_GLYPH-1].

## Timing
- Reset values: state IDLE, FETCH_BUSY 0, ROM_EN 0, ROM_ADDR 0, all line words 0, both pipeline stages 0. VGA_R/G/B = 0 and OUT_DE = 0 from the first cycle after RST.
- Fetch length: LINE_START at cycle t gives ROM_EN high for cycles t+1..t+N_GLYPH and the last capture at t+N_GLYPH+1. Default: 20 cycles, well inside the 160-cycle blanking.
- Render latency: exactly 2 cycles from PIX_X/PIX_Y/PIX_DE to VGA_R/G/B/OUT_DE, including the first and last active pixel.
- Line words are updated only by the fetch. Render reads whatever is held, so content for line L must be fetched in the blanking before L.
- RST asserted mid-fetch: the next cycle returns to IDLE with ROM_EN 0 and words cleared.

## Test plan
- Reset: hold RST 3 cycles mid-fetch -> ROM_EN=0, FETCH_BUSY=0, RGB=0, OUT_DE=0 on the following cycle.
- Fetch sequence: LINE_START with LINE_Y=161 -> ROM_ADDR 19..37 on 19 consecutive cycles, then FETCH_BUSY falls; ROM model returns addr-based words, and all 19 are captured correctly.
- Pixel mapping: word[0]=16'h8001 on line 161 -> FF0000 at PIX_X=144 and 159, 000000 at 145 and 160, each appearing 2 cycles after the input.
- Out of window: LINE_START with LINE_Y=200 -> no ROM_EN and words cleared; line 200 is all BG. PIX_X=448 on line 161 gives BG.
- Restart: second LINE_START 5 cycles into a fetch (LINE_Y=162) -> addresses restart at 38, and the stale read data is not written.
- Full frame: drive 800x525 timing with a checkerboard ROM -> the RGB capture matches the golden image pixel-exact and OUT_DE equals PIX_DE delayed 2 cycles.

Source files
------------

// File: rtl/vga_glyph_line.sv
// Glyph line renderer: fetches one glyph-strip row from a synchronous font ROM
// during horizontal blanking and renders it to registered RGB at two-cycle latency.
module vga_glyph_line #(
  parameter int          N_GLYPH = 19,
  parameter int          GLYPH_W = 16,
  parameter int          GLYPH_H = 32,
  parameter int          X0      = 144,
  parameter int          Y0      = 160,
  parameter int          ADDR_W  = 10,
  parameter logic [23:0] FG      = 24'hFF0000,
  parameter logic [23:0] BG      = 24'h000000
) (
  input  logic               CLK_25,
  input  logic               RST,
  input  logic               LINE_START,
  input  logic [10:0]        LINE_Y,
  input  logic [10:0]        PIX_X,
  input  logic [10:0]        PIX_Y,
  input  logic               PIX_DE,
  output logic               ROM_EN,
  output logic [ADDR_W-1:0]  ROM_ADDR,
  input  logic [GLYPH_W-1:0] ROM_DATA,
  output logic               FETCH_BUSY,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               OUT_DE
);

  localparam int IDX_W = (N_GLYPH > 1) ? $clog2(N_GLYPH) : 1;
  localparam int BIT_W = $clog2(GLYPH_W);
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + N_GLYPH * GLYPH_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + GLYPH_H);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr;
  logic               cap_vld;
  logic [IDX_W-1:0]   cap_idx;
  logic [GLYPH_W-1:0] words [N_GLYPH];
  logic [10:0]        row;
  logic               y_hit;
  logic               last_issue;

  assign row        = LINE_Y - Y_LO;
  assign y_hit      = (LINE_Y >= Y_LO) && (LINE_Y < Y_HI);
  assign last_issue = (cnt == IDX_W'(N_GLYPH - 1));
  assign ROM_EN     = (state == ISSUE);
  assign ROM_ADDR   = addr;
  assign FETCH_BUSY = (state == ISSUE) || (state == DRAIN);

  always_ff @(posedge CLK_25) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // LINE_START overrides whatever the fetch is doing, so it is decoded first.
  always_comb begin
    state_nx = state;
    if (LINE_START) begin
      state_nx = y_hit ? ISSUE : IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        ISSUE:   if (last_issue) state_nx = DRAIN;
        DRAIN:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_25) begin
    if (RST) begin
      cnt     <= '0;
      addr    <= '0;
      cap_vld <= 1'b0;
      cap_idx <= '0;
      for (int unsigned g = 0; g < N_GLYPH; g++) words[g] <= '0;
    end else begin
      // A read issued in the same cycle as LINE_START is in flight and dropped.
      cap_vld <= (state == ISSUE) && !LINE_START;
      cap_idx <= cnt;
      if (LINE_START) begin
        cnt <= '0;
        if (y_hit) begin
          addr <= ADDR_W'(row * N_GLYPH);
        end else begin
          for (int unsigned g = 0; g < N_GLYPH; g++) words[g] <= '0;
        end
      end else begin
        if (state == ISSUE) begin
          cnt  <= cnt + 1'b1;
          addr <= addr + 1'b1;
        end
        if (cap_vld) words[cap_idx] <= ROM_DATA;
      end
    end
  end

  logic [10:0]      dx;
  logic             in_win;
  logic             win1, de1;
  logic [IDX_W-1:0] widx1;
  logic [BIT_W-1:0] bidx1;
  logic [23:0]      rgb;

  assign dx     = PIX_X - X_LO;
  assign in_win = PIX_DE && (PIX_X >= X_LO) && (PIX_X < X_HI) &&
                  (PIX_Y >= Y_LO) && (PIX_Y < Y_HI);

  // Indices are forced to zero outside the window so the word lookup stays in range.
  always_ff @(posedge CLK_25) begin
    if (RST) begin
      win1  <= 1'b0;
      de1   <= 1'b0;
      widx1 <= '0;
      bidx1 <= '0;
      rgb   <= '0;
      OUT_DE <= 1'b0;
    end else begin
      win1  <= in_win;
      de1   <= PIX_DE;
      widx1 <= in_win ? IDX_W'(dx >> BIT_W) : '0;
      bidx1 <= in_win ? ~dx[BIT_W-1:0] : '0;
      OUT_DE <= de1;
      if (!de1)                            rgb <= '0;
      else if (win1 && words[widx1][bidx1]) rgb <= FG;
      else                                 rgb <= BG;
    end
  end

  assign VGA_R = rgb[23:16];
  assign VGA_G = rgb[15:8];
  assign VGA_B = rgb[7:0];

endmodule

// File: tb/tb_vga_glyph_line.sv
// Scoreboard bench for vga_glyph_line: ROM model, line-word model and pixel queue.
`timescale 1ns/1ps
module tb_vga_glyph_line;

  logic        CLK_25 = 1'b0;
  logic        RST = 1'b1;
  logic        LINE_START = 1'b0;
  logic [10:0] LINE_Y = '0;
  logic [10:0] PIX_X = '0;
  logic [10:0] PIX_Y = '0;
  logic        PIX_DE = 1'b0;
  logic        ROM_EN;
  logic [9:0]  ROM_ADDR;
  logic [15:0] ROM_DATA = '0;
  logic        FETCH_BUSY;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        OUT_DE;

  vga_glyph_line #(
    .N_GLYPH(19), .GLYPH_W(16), .GLYPH_H(32), .X0(144), .Y0(160),
    .ADDR_W(10), .FG(24'hFF0000), .BG(24'h000000)
  ) dut (
    .CLK_25(CLK_25), .RST(RST), .LINE_START(LINE_START), .LINE_Y(LINE_Y),
    .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_DE(PIX_DE),
    .ROM_EN(ROM_EN), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .FETCH_BUSY(FETCH_BUSY),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .OUT_DE(OUT_DE)
  );

  always #5 CLK_25 = ~CLK_25;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rom_mode = 0;
  logic [15:0] mw [19];

  typedef struct { int due; int x; int y; logic [24:0] val; } exp_t;
  exp_t sb[$];

  always @(posedge CLK_25) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [9:0] a);
    logic [31:0] p;
    int r, g;
    r = int'(a) / 19;
    g = int'(a) % 19;
    case (rom_mode)
      0: begin
        p = 32'(a) * 32'd40503;
        return p[15:0] ^ 16'h5A5A;
      end
      1: return (g == 0) ? 16'h8001 : 16'h0000;
      default: return (((r >> 2) ^ g) & 1) != 0 ? 16'hF0F0 : 16'h0F0F;
    endcase
  endfunction

  always @(posedge CLK_25) if (ROM_EN) ROM_DATA <= rom_word(ROM_ADDR);

  task automatic model_line(input int y);
    for (int g = 0; g < 19; g++)
      mw[g] = (y >= 160 && y < 192) ? rom_word(10'((y - 160) * 19 + g)) : 16'h0000;
  endtask

  function automatic logic [24:0] exp_pix(input int x, input int y, input logic de);
    int dx;
    logic [15:0] w;
    if (!de) return '0;
    if (x >= 144 && x < 448 && y >= 160 && y < 192) begin
      dx = x - 144;
      w = mw[dx / 16];
      if (w[15 - (dx % 16)]) return {1'b1, 24'hFF0000};
    end
    return {1'b1, 24'h000000};
  endfunction

  always @(negedge CLK_25) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("pix x%0d y%0d", e.x, e.y), {7'd0, OUT_DE, VGA_R, VGA_G, VGA_B}, {7'd0, e.val});
    end
  end

  task automatic pix(input int x, input int y, input logic de, input logic [24:0] e);
    @(posedge CLK_25); #1;
    PIX_X = 11'(x); PIX_Y = 11'(y); PIX_DE = de;
    sb.push_back('{due: cyc + 2, x: x, y: y, val: e});
  endtask

  task automatic render_line(input int y, input int nxt);
    for (int x = 0; x < 800; x++) begin
      @(posedge CLK_25); #1;
      PIX_X = 11'(x); PIX_Y = 11'(y); PIX_DE = (x < 640);
      LINE_START = (nxt >= 0 && x == 640);
      if (LINE_START) begin
        LINE_Y = 11'(nxt);
        model_line(nxt);
      end
      sb.push_back('{due: cyc + 2, x: x, y: y, val: exp_pix(x, y, x < 640)});
    end
    @(posedge CLK_25); #1;
    LINE_START = 1'b0; PIX_DE = 1'b0;
  endtask

  task automatic start_line(input int y);
    @(posedge CLK_25); #1;
    LINE_START = 1'b1; LINE_Y = 11'(y);
    @(posedge CLK_25); #1;
    LINE_START = 1'b0;
  endtask

  task automatic fetch_check(input int y);
    start_line(y);
    if (y >= 160 && y < 192) begin
      for (int g = 0; g < 19; g++) begin
        @(negedge CLK_25);
        chk($sformatf("rom_en y%0d g%0d", y, g), 32'(ROM_EN), 32'd1);
        chk($sformatf("rom_addr y%0d g%0d", y, g), 32'(ROM_ADDR), 32'((y - 160) * 19 + g));
      end
      @(negedge CLK_25);
      chk("drain_busy", 32'(FETCH_BUSY), 32'd1);
      chk("drain_rom_en", 32'(ROM_EN), 32'd0);
      @(negedge CLK_25);
      chk("busy_fall", 32'(FETCH_BUSY), 32'd0);
    end else begin
      for (int k = 0; k < 21; k++) begin
        @(negedge CLK_25);
        chk($sformatf("oow_rom_en k%0d", k), 32'(ROM_EN), 32'd0);
        chk($sformatf("oow_busy k%0d", k), 32'(FETCH_BUSY), 32'd0);
      end
    end
    model_line(y);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_line(0);
    repeat (3) @(posedge CLK_25);
    #1 RST = 1'b0;
    @(negedge CLK_25);
    chk("rst_rom_en", 32'(ROM_EN), 32'd0);
    chk("rst_rom_addr", 32'(ROM_ADDR), 32'd0);
    chk("rst_busy", 32'(FETCH_BUSY), 32'd0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("rst_de", 32'(OUT_DE), 32'd0);

    rom_mode = 0;
    fetch_check(161);
    render_line(161, -1);

    rom_mode = 1;
    fetch_check(161);
    pix(144, 161, 1'b1, {1'b1, 24'hFF0000});
    pix(145, 161, 1'b1, {1'b1, 24'h000000});
    pix(159, 161, 1'b1, {1'b1, 24'hFF0000});
    pix(160, 161, 1'b1, {1'b1, 24'h000000});
    pix(448, 161, 1'b1, {1'b1, 24'h000000});
    pix(144, 161, 1'b0, 25'd0);
    repeat (3) pix(0, 0, 1'b0, 25'd0);

    fetch_check(200);
    render_line(161, -1);
    render_line(200, -1);

    rom_mode = 0;
    start_line(161);
    repeat (3) @(posedge CLK_25);
    fetch_check(162);
    render_line(162, -1);

    start_line(161);
    repeat (3) @(posedge CLK_25);
    fetch_check(200);
    render_line(161, -1);

    fetch_check(161);
    start_line(162);
    repeat (2) @(posedge CLK_25);
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK_25);
    #1 RST = 1'b0;
    @(negedge CLK_25);
    chk("midrst_rom_en", 32'(ROM_EN), 32'd0);
    chk("midrst_busy", 32'(FETCH_BUSY), 32'd0);
    chk("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 32'd0);
    chk("midrst_de", 32'(OUT_DE), 32'd0);
    @(negedge CLK_25);
    chk("midrst_rom_en2", 32'(ROM_EN), 32'd0);
    model_line(0);
    render_line(162, -1);

    rom_mode = 2;
    start_line(157);
    model_line(157);
    for (int y = 157; y < 195; y++) render_line(y, y + 1);

    repeat (4) @(posedge CLK_25);
    @(negedge CLK_25);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
